// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU dispatch front-end: opcodes, sequencer states
// and the tick counter width.
package fpu_pkg;

    localparam logic [3:0] OP_NRF = 4'd0;
    localparam logic [3:0] OP_AD  = 4'd1;
    localparam logic [3:0] OP_SD  = 4'd2;
    localparam logic [3:0] OP_MW  = 4'd3;
    localparam logic [3:0] OP_DW  = 4'd4;
    localparam logic [3:0] OP_AF  = 4'd5;
    localparam logic [3:0] OP_SF  = 4'd6;
    localparam logic [3:0] OP_MF  = 4'd7;
    localparam logic [3:0] OP_DF  = 4'd8;

    localparam int CNT_W = 13;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_GOT,
        S_RUN,
        S_DONE,
        S_ALARM
    } state_t;

    // Opcodes above DF have no F-PS operation behind them.
    function automatic logic op_legal(input logic [3:0] op);
        return op <= OP_DF;
    endfunction

endpackage

// File: rtl/fpu_dispatch_if.sv
// CPU-side and F-PS-side signals of the dispatch block, bundled as one interface.
// req/busy handshake: the CPU may raise req (with op) only while busy is low; the
// request is taken on that edge, busy stays high until the cycle after the
// one-cycle ack, and req seen while busy is high is dropped (no queueing).
interface fpu_dispatch_if;

    logic                 req;
    logic [3:0]           op;
    logic                 abort;
    logic                 ekc_fp;
    logic                 busy;
    logic                 ack;
    logic                 illegal;
    logic                 alarm;
    logic                 efp;
    logic                 got;
    logic                 nrf, ad, sf, af, sd;
    logic                 mw_, dw_, mf_, df_;
    logic                 ad_sd, af_sf, dw_df, mw_mf;
    fpu_pkg::state_t      dbg_state;

    modport master (
        output req, op, abort, ekc_fp,
        input  busy, ack, illegal, alarm, efp, got,
        input  nrf, ad, sf, af, sd, mw_, dw_, mf_, df_,
        input  ad_sd, af_sf, dw_df, mw_mf, dbg_state
    );

    modport slave (
        input  req, op, abort, ekc_fp,
        output busy, ack, illegal, alarm, efp, got,
        output nrf, ad, sf, af, sd, mw_, dw_, mf_, df_,
        output ad_sd, af_sf, dw_df, mw_mf, dbg_state
    );

endinterface

// File: rtl/fpu_op_decode.sv
// Static operation-select decode for F-PS; with en low every line sits at its
// inactive polarity.
module fpu_op_decode
    import fpu_pkg::*;
(
    input  logic [3:0] opr,
    input  logic       en,
    output logic       nrf,
    output logic       ad,
    output logic       sd,
    output logic       af,
    output logic       sf,
    output logic       mw_,
    output logic       dw_,
    output logic       mf_,
    output logic       df_,
    output logic       ad_sd,
    output logic       af_sf,
    output logic       dw_df,
    output logic       mw_mf
);

    logic is_mw, is_dw, is_mf, is_df;

    assign nrf   = en && (opr == OP_NRF);
    assign ad    = en && (opr == OP_AD);
    assign sd    = en && (opr == OP_SD);
    assign af    = en && (opr == OP_AF);
    assign sf    = en && (opr == OP_SF);

    assign is_mw = en && (opr == OP_MW);
    assign is_dw = en && (opr == OP_DW);
    assign is_mf = en && (opr == OP_MF);
    assign is_df = en && (opr == OP_DF);

    assign mw_   = !is_mw;
    assign dw_   = !is_dw;
    assign mf_   = !is_mf;
    assign df_   = !is_df;

    assign ad_sd = ad || sd;
    assign af_sf = af || sf;
    assign dw_df = is_dw || is_df;
    assign mw_mf = is_mw || is_mf;

endmodule

// File: rtl/fpu_dispatch.sv
// Sequencer between the CPU decoder and F-PS: latches the opcode, issues the
// efp/got start sequence, waits for ekc_fp and acknowledges, with a watchdog.
module fpu_dispatch
    import fpu_pkg::*;
#(
    parameter int GOT_TICKS     = 2,
    parameter int TIMEOUT_TICKS = 4096
) (
    input  logic          __clk,
    input  logic          clr_,
    fpu_dispatch_if.slave bus
);

    localparam logic [CNT_W-1:0] GOT_LAST = CNT_W'(GOT_TICKS - 1);
    localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(TIMEOUT_TICKS - 1);

    state_t           state;
    logic [3:0]       opr;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             ekc_q;
    logic             ekc_rise;
    logic             sel_en;
    logic             busy_q, ack_q, illegal_q, alarm_q, efp_q, got_q;

    // Saturating: a stuck counter is harmless, a wrapped one would re-arm the watchdog.
    assign cnt_inc  = (cnt == '1) ? cnt : cnt + 1'b1;
    assign ekc_rise = bus.ekc_fp && !ekc_q;
    assign sel_en   = (state == S_ARM) || (state == S_GOT) ||
                      (state == S_RUN) || (state == S_DONE);

    always_ff @(posedge __clk or negedge clr_) begin
        if (!clr_) begin
            state     <= S_IDLE;
            opr       <= '0;
            cnt       <= '0;
            ekc_q     <= 1'b0;
            busy_q    <= 1'b0;
            ack_q     <= 1'b0;
            illegal_q <= 1'b0;
            alarm_q   <= 1'b0;
            efp_q     <= 1'b0;
            got_q     <= 1'b0;
        end else begin
            ekc_q     <= bus.ekc_fp;
            ack_q     <= 1'b0;
            illegal_q <= 1'b0;
            efp_q     <= 1'b0;
            if (bus.abort) begin
                state   <= S_IDLE;
                cnt     <= '0;
                busy_q  <= 1'b0;
                got_q   <= 1'b0;
                alarm_q <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (bus.req) begin
                            if (op_legal(bus.op)) begin
                                opr    <= bus.op;
                                state  <= S_ARM;
                                busy_q <= 1'b1;
                                efp_q  <= 1'b1;
                            end else begin
                                illegal_q <= 1'b1;
                            end
                        end
                    end
                    S_ARM: begin
                        state <= S_GOT;
                        cnt   <= '0;
                        got_q <= 1'b1;
                    end
                    S_GOT: begin
                        if (cnt == GOT_LAST) begin
                            state <= S_RUN;
                            cnt   <= '0;
                            got_q <= 1'b0;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    S_RUN: begin
                        cnt <= cnt_inc;
                        // Completion beats the watchdog on the terminal-count cycle.
                        if (ekc_rise) begin
                            state <= S_DONE;
                            ack_q <= 1'b1;
                        end else if (cnt == RUN_LAST) begin
                            state   <= S_ALARM;
                            alarm_q <= 1'b1;
                        end
                    end
                    S_DONE: begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                    end
                    S_ALARM: begin
                        state <= S_ALARM;
                    end
                    default: begin
                        state   <= S_IDLE;
                        busy_q  <= 1'b0;
                        got_q   <= 1'b0;
                        alarm_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.busy      = busy_q;
    assign bus.ack       = ack_q;
    assign bus.illegal   = illegal_q;
    assign bus.alarm     = alarm_q;
    assign bus.efp       = efp_q;
    assign bus.got       = got_q;
    assign bus.dbg_state = state;

    fpu_op_decode u_decode (
        .opr   (opr),
        .en    (sel_en),
        .nrf   (bus.nrf),
        .ad    (bus.ad),
        .sd    (bus.sd),
        .af    (bus.af),
        .sf    (bus.sf),
        .mw_   (bus.mw_),
        .dw_   (bus.dw_),
        .mf_   (bus.mf_),
        .df_   (bus.df_),
        .ad_sd (bus.ad_sd),
        .af_sf (bus.af_sf),
        .dw_df (bus.dw_df),
        .mw_mf (bus.mw_mf)
    );

endmodule

// File: tb/tb_fpu_dispatch.sv
// Self-checking bench for fpu_dispatch: expected output timelines are derived
// from cycle offsets after the accepted request.
module tb_fpu_dispatch;
  import fpu_pkg::*;

  localparam int G = 2;
  localparam int T = 16;

  logic clk;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  fpu_dispatch_if bus();

  fpu_dispatch #(.GOT_TICKS(G), .TIMEOUT_TICKS(T)) dut (
    .__clk (clk),
    .clr_  (rst_n),
    .bus   (bus)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // reference: {busy,ack,illegal,alarm,efp,got,nrf,ad,sd,af,sf,mw_,dw_,mf_,df_,ad_sd,af_sf,dw_df,mw_mf}
  function automatic logic [18:0] model_out(input logic busy, input logic ack, input logic ill,
                                            input logic alarm, input logic efp, input logic got,
                                            input logic sel_on, input logic [3:0] op);
    logic nrf, ad, sd, af, sf, mw, dw, mf, df;
    nrf = sel_on && op == OP_NRF;
    ad  = sel_on && op == OP_AD;
    sd  = sel_on && op == OP_SD;
    af  = sel_on && op == OP_AF;
    sf  = sel_on && op == OP_SF;
    mw  = sel_on && op == OP_MW;
    dw  = sel_on && op == OP_DW;
    mf  = sel_on && op == OP_MF;
    df  = sel_on && op == OP_DF;
    return {busy, ack, ill, alarm, efp, got, nrf, ad, sd, af, sf,
            !mw, !dw, !mf, !df, ad || sd, af || sf, dw || df, mw || mf};
  endfunction

  function automatic logic [18:0] sample_out();
    return {bus.busy, bus.ack, bus.illegal, bus.alarm, bus.efp, bus.got,
            bus.nrf, bus.ad, bus.sd, bus.af, bus.sf,
            bus.mw_, bus.dw_, bus.mf_, bus.df_,
            bus.ad_sd, bus.af_sf, bus.dw_df, bus.mw_mf};
  endfunction

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req    = 1'b0;
    bus.op     = 4'd0;
    bus.abort  = 1'b0;
    bus.ekc_fp = 1'b0;
  endtask

  // One request from the current IDLE cycle. d: RUN cycle index where ekc_fp
  // rises (d >= T means never). abort_t: cycle after the request carrying abort.
  task automatic run_txn(input logic [3:0] op_i, input int d, input bit noise,
                         input int abort_t_i, input string name);
    int t_run, t_ack, t_alarm, t_end, abort_t, hold;
    bit timed_out, aborted, bz, ak, al, ef, gt;
    logic [18:0] exp_v, obs_v;
    t_run     = 2 + G;
    timed_out = (d >= T);
    t_ack     = t_run + d + 1;
    t_alarm   = t_run + T;
    abort_t   = abort_t_i;
    if (timed_out && abort_t == 0) abort_t = t_alarm + 3;
    t_end     = (abort_t > 0) ? abort_t + 1 : t_ack + 1;
    hold      = $urandom_range(1, 3);
    bus.req    = 1'b1;
    bus.op     = op_i;
    bus.abort  = 1'b0;
    bus.ekc_fp = 1'b0;
    for (int t = 1; t <= t_end; t++) begin
      step();
      aborted = (abort_t > 0) && (t > abort_t);
      bz = !aborted && (timed_out || t <= t_ack);
      ef = !aborted && (t == 1);
      gt = !aborted && (t >= 2) && (t <= 1 + G);
      ak = !aborted && !timed_out && (t == t_ack);
      al = !aborted && timed_out && (t >= t_alarm);
      exp_v = model_out(bz, ak, 1'b0, al, ef, gt, bz && !al, op_i);
      obs_v = sample_out();
      n_tests++;
      if (obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL %s op=%0d d=%0d cycle=%0d outputs=%b expected=%b",
                 name, op_i, d, t, obs_v, exp_v);
      end
      bus.req    = noise && bz && ($urandom_range(0, 1) == 1);
      bus.op     = bus.req ? 4'($urandom_range(0, 15)) : op_i;
      bus.ekc_fp = !timed_out && (t >= t_run + d) && (t < t_run + d + hold);
      bus.abort  = (t == abort_t);
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    logic [18:0] exp_v;
    rst_n = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    exp_v = model_out(0, 0, 0, 0, 0, 0, 0, 4'd0);
    n_tests++;
    if (sample_out() !== exp_v) begin
      n_fail++;
      $display("FAIL reset_outputs outputs=%b expected=%b", sample_out(), exp_v);
    end
    n_tests++;
    if (bus.dbg_state !== S_IDLE) begin
      n_fail++;
      $display("FAIL reset_state state=%0d expected=%0d", bus.dbg_state, S_IDLE);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    n_tests++;
    if (sample_out() !== exp_v) begin
      n_fail++;
      $display("FAIL post_reset_idle outputs=%b expected=%b", sample_out(), exp_v);
    end
  endtask

  task automatic test_dw_sequence();
    run_txn(OP_DW, 10, 1'b0, 0, "dw_sequence");
  endtask

  task automatic test_illegal();
    logic [3:0] bad;
    logic [18:0] exp_v;
    for (int k = 0; k < 4; k++) begin
      bad = (k == 0) ? 4'd12 : 4'($urandom_range(9, 15));
      bus.req = 1'b1;
      bus.op  = bad;
      step();
      bus.req = 1'b0;
      exp_v = model_out(0, 0, 1, 0, 0, 0, 0, bad);
      n_tests++;
      if (sample_out() !== exp_v) begin
        n_fail++;
        $display("FAIL illegal_pulse op=%0d outputs=%b expected=%b", bad, sample_out(), exp_v);
      end
      step();
      exp_v = model_out(0, 0, 0, 0, 0, 0, 0, bad);
      n_tests++;
      if (sample_out() !== exp_v) begin
        n_fail++;
        $display("FAIL illegal_single op=%0d outputs=%b expected=%b", bad, sample_out(), exp_v);
      end
    end
  endtask

  task automatic test_ignore_req();
    run_txn(OP_AD, 6, 1'b1, 0, "ignore_req");
  endtask

  task automatic test_timeout();
    run_txn(OP_MF, T + 5, 1'b0, 0, "timeout_alarm");
  endtask

  task automatic test_terminal_edge();
    run_txn(OP_SF, T - 1, 1'b0, 0, "terminal_edge");
  endtask

  task automatic test_abort_edge();
    run_txn(OP_DF, 5, 1'b0, 2 + G + 5, "abort_edge");
  endtask

  task automatic test_abort_idle();
    logic [18:0] exp_v;
    exp_v = model_out(0, 0, 0, 0, 0, 0, 0, OP_AF);
    bus.req   = 1'b1;
    bus.op    = OP_AF;
    bus.abort = 1'b1;
    step();
    idle_inputs();
    n_tests++;
    if (sample_out() !== exp_v) begin
      n_fail++;
      $display("FAIL abort_idle_req outputs=%b expected=%b", sample_out(), exp_v);
    end
    step();
    n_tests++;
    if (sample_out() !== exp_v) begin
      n_fail++;
      $display("FAIL abort_idle_after outputs=%b expected=%b", sample_out(), exp_v);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [18:0] exp_v;
    bus.req = 1'b1;
    bus.op  = OP_MW;
    step();
    bus.req = 1'b0;
    repeat (G + 4) step();
    exp_v = model_out(1, 0, 0, 0, 0, 0, 1, OP_MW);
    n_tests++;
    if (sample_out() !== exp_v) begin
      n_fail++;
      $display("FAIL mid_run_active outputs=%b expected=%b", sample_out(), exp_v);
    end
    #2;
    rst_n = 1'b0;
    #1;
    exp_v = model_out(0, 0, 0, 0, 0, 0, 0, OP_MW);
    n_tests++;
    if (sample_out() !== exp_v) begin
      n_fail++;
      $display("FAIL reset_async outputs=%b expected=%b", sample_out(), exp_v);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      n_tests++;
      if (sample_out() !== exp_v) begin
        n_fail++;
        $display("FAIL post_reset_quiet cycle=%0d outputs=%b expected=%b", k, sample_out(), exp_v);
      end
    end
    run_txn(OP_NRF, 3, 1'b0, 0, "restart_after_reset");
  endtask

  task automatic test_back_to_back();
    run_txn(OP_SD, 0, 1'b0, 0, "back_to_back_0");
    run_txn(OP_AF, 2, 1'b0, 0, "back_to_back_1");
    run_txn(OP_MW, 1, 1'b0, 0, "back_to_back_2");
  endtask

  task automatic test_random();
    logic [3:0] op_r;
    int d, ab, lim;
    for (int k = 0; k < 12; k++) begin
      op_r = 4'($urandom_range(0, 8));
      d    = $urandom_range(0, 20);
      lim  = 2 + G + ((d < T) ? d : T);
      ab   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, lim) : 0;
      run_txn(op_r, d, 1'($urandom_range(0, 1)), ab, "random_txn");
    end
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    test_reset();
    test_dw_sequence();
    test_illegal();
    test_ignore_req();
    test_timeout();
    test_terminal_edge();
    test_abort_edge();
    test_abort_idle();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
